// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encoding, redirect priorities, boot and exception vectors.
// Pure types/constants; no logic, no latency, no flow control.
package cpu_defs;

   localparam logic [31:0] RESET_VEC_DEF = 32'hbfc00000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'hbfc00380;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_t;

   // Numeric order is the redirect priority order; NONE must stay lowest.
   typedef enum logic [1:0] {
      PRI_NONE = 2'd0,
      PRI_BR   = 2'd1,
      PRI_ERET = 2'd2,
      PRI_EXC  = 2'd3
   } redir_pri_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect priority encoder: exception > eret > branch; combinational, zero latency.
// No flow control; target is only meaningful when pri != PRI_NONE.
module pc_redirect_arb
   import cpu_defs::*;
#(
   parameter int                WIDTH   = 32,
   parameter logic [WIDTH-1:0]  EXC_VEC = WIDTH'(EXC_VEC_DEF)
) (
   input  logic             exception,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   output logic [WIDTH-1:0] target,
   output redir_pri_t       pri
);

   always_comb begin
      target = '0;
      pri    = PRI_NONE;
      if (exception) begin
         target = EXC_VEC;
         pri    = PRI_EXC;
      end else if (eret) begin
         target = epc;
         pri    = PRI_ERET;
      end else if (br_valid) begin
         target = br_target;
         pri    = PRI_BR;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC controller: one outstanding fetch, redirects deferred until it completes.
// Request issues one cycle after IDLE; stall only gates new requests, never an issued one.
module pc_fetch_ctrl
   import cpu_defs::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
   parameter int unsigned      STEP      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             exception,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   output logic             inst_req,
   output logic [WIDTH-1:0] inst_addr,
   input  logic             inst_addr_ok,
   input  logic             inst_data_ok,
   output logic [WIDTH-1:0] pc,
   output logic             fetch_valid,
   output logic             adel
);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic             cancel;
   logic [WIDTH-1:0] pend_target;
   redir_pri_t       pend_pri;

   logic [WIDTH-1:0] arb_target;
   redir_pri_t       arb_pri;
   logic             redir;
   logic             take_redir;
   logic             done;

   assign adel = (pc[1:0] != 2'b00);

   // A misaligned pc can only be escaped by exception or eret, so branches are masked.
   pc_redirect_arb #(
      .WIDTH   (WIDTH),
      .EXC_VEC (EXC_VEC)
   ) u_arb (
      .exception (exception),
      .eret      (eret),
      .epc       (epc),
      .br_valid  (br_valid & ~adel),
      .br_target (br_target),
      .target    (arb_target),
      .pri       (arb_pri)
   );

   assign redir      = (arb_pri != PRI_NONE);
   // pend_pri is PRI_NONE whenever nothing is pending, so any redirect wins then.
   assign take_redir = redir && (arb_pri >= pend_pri);
   assign done       = (state == ST_WAIT) && inst_data_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A redirect taken in IDLE uses up that cycle so the new pc is alignment-checked before issue.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (!redir && !stall && !adel) state_nxt = ST_REQ;
         ST_REQ:  if (inst_addr_ok)              state_nxt = ST_WAIT;
         ST_WAIT: if (inst_data_ok)              state_nxt = ST_IDLE;
         default:                                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      inst_req    = (state == ST_REQ);
      inst_addr   = pc;
      fetch_valid = done && !cancel && !redir;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_VEC;
         cancel      <= 1'b0;
         pend_target <= '0;
         pend_pri    <= PRI_NONE;
      end else if (state == ST_IDLE) begin
         if (redir) pc <= arb_target;
      end else if (done) begin
         cancel   <= 1'b0;
         pend_pri <= PRI_NONE;
         if (take_redir)  pc <= arb_target;
         else if (cancel) pc <= pend_target;
         else             pc <= pc + WIDTH'(STEP);
      end else if (take_redir) begin
         pend_target <= arb_target;
         pend_pri    <= arb_pri;
         cancel      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: per-cycle vector table plus hand-written reset/handshake sequences.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, exception, eret, br_valid;
   logic [31:0] epc, br_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] pc;
   logic        fetch_valid, adel;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .exception    (exception),
      .eret         (eret),
      .epc          (epc),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .pc           (pc),
      .fetch_valid  (fetch_valid),
      .adel         (adel)
   );

   typedef struct {
      logic        rst, stall, exc, eret;
      logic [31:0] epc;
      logic        br;
      logic [31:0] brt;
      logic        aok, dok;
      logic        req;
      logic [31:0] pc;
      logic        fv, adel;
   } vec_t;

   vec_t tbl[$];

   task automatic v(input logic r, s, x, e, input logic [31:0] ep, input logic b,
                    input logic [31:0] bt, input logic ao, d, input logic q,
                    input logic [31:0] p, input logic f, a);
      vec_t t;
      t = '{rst:r, stall:s, exc:x, eret:e, epc:ep, br:b, brt:bt, aok:ao, dok:d,
            req:q, pc:p, fv:f, adel:a};
      tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input vec_t t);
      rst          = t.rst;
      stall        = t.stall;
      exception    = t.exc;
      eret         = t.eret;
      epc          = t.epc;
      br_valid     = t.br;
      br_target    = t.brt;
      inst_addr_ok = t.aok;
      inst_data_ok = t.dok;
   endtask

   initial begin
      vec_t idle;
      int   waited;
      idle = '{rst:0, stall:0, exc:0, eret:0, epc:0, br:0, brt:0, aok:0, dok:0,
               req:0, pc:0, fv:0, adel:0};
      drive(idle);
      rst = 1'b1;

      //  rst s  x  e  epc           br brt           ao d  | req pc            fv adel
      v(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00000, 0, 0); // 0 reset
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00000, 0, 0); // 1
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0,   1, 32'hbfc00000, 0, 0); // 2 first req
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00000, 0, 0); // 3 wait
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'hbfc00000, 1, 0); // 4 data
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00004, 0, 0); // 5 seq +4
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0,   1, 32'hbfc00004, 0, 0); // 6
      v(0, 0, 0, 0, 32'h0,        1, 32'h80001000, 0, 0,   0, 32'hbfc00004, 0, 0); // 7 br in WAIT
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'hbfc00004, 0, 0); // 8 cancelled
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h80001000, 0, 0); // 9
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h80001000, 0, 0); // 10
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0,   1, 32'h80001000, 0, 0); // 11
      v(0, 0, 1, 0, 32'h0,        1, 32'h80009000, 0, 1,   0, 32'h80001000, 0, 0); // 12 exc+br at data
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00380, 0, 0); // 13
      v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'hbfc00380, 0, 0); // 14 stall in REQ
      v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0,   1, 32'hbfc00380, 0, 0); // 15
      v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'hbfc00380, 1, 0); // 16
      v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00384, 0, 0); // 17 held idle
      v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00384, 0, 0); // 18
      v(0, 0, 0, 1, 32'h80000002, 0, 32'h0,        0, 0,   0, 32'hbfc00384, 0, 0); // 19 eret misaligned
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h80000002, 0, 1); // 20 adel
      v(0, 0, 0, 0, 32'h0,        1, 32'h80002000, 0, 0,   0, 32'h80000002, 0, 1); // 21 br ignored
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h80000002, 0, 1); // 22
      v(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h80000002, 0, 1); // 23 exc clears
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00380, 0, 0); // 24
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0,   1, 32'hbfc00380, 0, 0); // 25
      v(0, 0, 0, 0, 32'h0,        1, 32'h80003000, 0, 0,   0, 32'hbfc00380, 0, 0); // 26 br pending
      v(0, 0, 0, 1, 32'h80004000, 0, 32'h0,        0, 0,   0, 32'hbfc00380, 0, 0); // 27 eret overrides
      v(0, 0, 0, 0, 32'h0,        1, 32'h80005000, 0, 0,   0, 32'hbfc00380, 0, 0); // 28 br dropped
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'hbfc00380, 0, 0); // 29
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h80004000, 0, 0); // 30
      v(0, 0, 0, 1, 32'h80006000, 0, 32'h0,        0, 0,   1, 32'h80004000, 0, 0); // 31 eret in REQ
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0,   1, 32'h80004000, 0, 0); // 32 addr held
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h80004000, 0, 0); // 33
      v(0, 0, 0, 0, 32'h0,        1, 32'hfffffffc, 0, 0,   0, 32'h80006000, 0, 0); // 34 br in IDLE
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hfffffffc, 0, 0); // 35
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0,   1, 32'hfffffffc, 0, 0); // 36
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'hfffffffc, 1, 0); // 37
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h00000000, 0, 0); // 38 wrapped
      v(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00000, 0, 0); // 39 reset mid-REQ
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'hbfc00000, 0, 0); // 40 late data_ok
      v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'hbfc00000, 0, 0); // 41

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d", i), {inst_req, inst_addr, pc, fetch_valid, adel},
             {tbl[i].req, tbl[i].pc, tbl[i].pc, tbl[i].fv, tbl[i].adel});
      end

      // Async reset in the middle of WAIT, checked without a clock edge.
      @(negedge clk);
      drive(idle);
      inst_addr_ok = 1'b1;
      @(negedge clk);
      inst_addr_ok = 1'b0;
      #1;
      chk("wait_entered", {65'd0, inst_req, fetch_valid}, 67'd0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", {2'd0, inst_req, pc, 32'd0}, {2'd0, 1'b0, 32'hbfc00000, 32'd0});
      @(negedge clk);
      rst = 1'b0;

      // Bounded wait for the first request after reset release.
      waited = 0;
      for (int k = 0; k < 6 && !inst_req; k++) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("req_after_rst", {2'd0, inst_req, inst_addr, 32'(waited)},
          {2'd0, 1'b1, 32'hbfc00000, 32'd1});
      inst_addr_ok = 1'b1;
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1;
      #1;
      chk("fv_after_rst", {66'd0, fetch_valid}, 67'd1);
      @(negedge clk);
      inst_data_ok = 1'b0;
      #1;
      chk("pc_after_rst", {35'd0, pc}, {35'd0, 32'hbfc00004});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, address width.
REQ-002 Parameter RESET_VEC, default 32'hbfc00000, PC after reset.
REQ-003 Parameter EXC_VEC, default 32'hbfc00380, exception entry address.
REQ-004 Parameter STEP, default 4, sequential increment.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stall  in  1  pipeline stall; blocks issue of a new fetch.
REQ-008 exception  in  1  synchronous exception redirect request.
REQ-009 eret  in  1  return-from-exception redirect request.
REQ-010 epc  in  WIDTH  eret target.
REQ-011 br_valid  in  1  branch/jump redirect request.
REQ-012 br_target  in  WIDTH  branch/jump target.
REQ-013 inst_req  out  1  fetch request to instruction memory.
REQ-014 inst_addr  out  WIDTH  fetch address; equals pc.
REQ-015 inst_addr_ok  in  1  request accepted.
REQ-016 inst_data_ok  in  1  fetch data returned.
REQ-017 pc  out  WIDTH  address of the fetch currently in progress.
REQ-018 fetch_valid  out  1  one-cycle pulse: returned data belongs to pc and is not cancelled.
REQ-019 adel  out  1  misaligned fetch address error (pc[1:0] != 0).

Function
REQ-020 FSM states IDLE, REQ, WAIT.
REQ-021 IDLE -> REQ when stall=0 and adel=0; otherwise stay in IDLE.
REQ-022 REQ: inst_req=1; -> WAIT on inst_addr_ok=1; request is never withdrawn once raised, regardless of stall or redirects.
REQ-023 WAIT: -> IDLE on inst_data_ok=1; fetch_valid=1 in that cycle only if cancel flag is clear.
REQ-024 Redirect priority: exception > eret > br_valid > sequential (pc+STEP).
REQ-025 Sequential advance pc <= pc+STEP on the WAIT->IDLE transition; arithmetic modulo 2^WIDTH (wraps to 0).
REQ-026 Redirect in IDLE: pc loads target at that edge; no fetch is cancelled.
REQ-027 Redirect in REQ or WAIT: target captured in pending register, cancel flag set; pc and inst_addr held until the outstanding fetch completes (inst_data_ok).
REQ-028 On completion of a cancelled fetch: fetch_valid=0, pc <= pending target, cancel cleared.
REQ-029 A later redirect while one is pending overwrites the pending target only if it has equal or higher priority; a lower-priority one is dropped.
REQ-030 Redirect coincident with inst_data_ok in WAIT: current data is cancelled and pc <= redirect target directly.
REQ-031 adel = (pc[1:0] != 0) combinationally; while adel=1 no request issues; only exception or eret clears it by loading a new pc.
REQ-032 Exception and eret are sampled synchronously (not asynchronous set).

Reset
REQ-033 On rst: pc=RESET_VEC, state=IDLE, inst_req=0, fetch_valid=0, cancel=0, pending target=0.
REQ-034 Reset mid-fetch abandons the transaction; a late inst_data_ok after reset is ignored because the FSM is in IDLE.
REQ-035 First request issues in the first cycle after rst deasserts with stall=0.

Structure
REQ-036 FSM state encoding, RESET_VEC, and EXC_VEC live in the shared cpu_defs package.
REQ-037 Sub-module pc_redirect_arb: combinational priority encoder producing target and priority level.

Verification
REQ-038 Reset release with stall=0, inst_addr_ok=1 next cycle, data_ok 2 cycles later -> inst_addr=bfc00000, fetch_valid pulse, pc=bfc00004.
REQ-039 br_valid target 0x80001000 asserted during WAIT -> that fetch returns with fetch_valid=0; next inst_addr=0x80001000.
REQ-040 exception and br_valid in the same cycle -> next fetch address bfc00380.
REQ-041 eret with epc=0x80000002 -> adel=1, inst_req stays 0; then exception -> pc=bfc00380, adel=0.
REQ-042 stall=1 asserted while in REQ -> inst_req stays 1 until inst_addr_ok; no new request afterwards until stall=0.
REQ-043 pc=FFFFFFFC sequential fetch completes -> pc wraps to 00000000.
